bin2bcd_seq: RTL and testbench

//  Sequential 3-channel binary-to-BCD converter (shift-add-3 / double dabble).

---
 rtl/bin2bcd_seq.sv | 171 +++++++++++++++++
 tb/tb_bin2bcd_seq.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential 3-channel binary-to-BCD converter (shift-add-3), one channel at a time.
// Optional feature macro: OVF_BLANK_EN (overflowed channels show 12'hFFF instead of 12'h999).
module bin2bcd_seq #(
  parameter int BIN_W = 10
) (
  input  logic             clk,
  input  logic             RSTn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BIN_W-1:0] bin0,
  input  logic [BIN_W-1:0] bin1,
  input  logic [BIN_W-1:0] bin2,
  output logic [11:0]      dec0,
  output logic [11:0]      dec1,
  output logic [11:0]      dec2,
  output logic [2:0]       ovf,
  output logic             out_valid
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] SHIFT = 3'd2;
  localparam logic [2:0] STORE = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]       state;
  logic [1:0]       ch;
  logic [3:0]       cnt;
  logic [21:0]      sh;
  logic             skip;
  logic [BIN_W-1:0] cap0, cap1, cap2;
  logic [11:0]      temp0, temp1, temp2;
  logic [2:0]       ovf_tmp;
  logic [9:0]       sel;
  logic [11:0]      adj;

  function automatic logic [11:0] add3(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    for (int k = 0; k < 3; k++) begin
      if (r[4*k +: 4] >= 4'd5) begin
        r[4*k +: 4] = r[4*k +: 4] + 4'd3;
      end else begin
        r[4*k +: 4] = r[4*k +: 4];
      end
    end
    return r;
  endfunction

  // Current channel's captured value, zero-extended to 10 bits, and the add-3 adjusted BCD field
  always_comb begin
    sel = 10'd0;
    case (ch)
      2'd0:    sel = 10'(cap0);
      2'd1:    sel = 10'(cap1);
      2'd2:    sel = 10'(cap2);
      default: sel = 10'd0;
    endcase
    adj = add3(sh[21:10]);
  end

  // Conversion FSM and registered outputs
  always_ff @(posedge clk) begin
    if (RSTn) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      dec0      <= 12'h000;
      dec1      <= 12'h000;
      dec2      <= 12'h000;
      ovf       <= 3'b000;
      ch        <= 2'd0;
      cnt       <= 4'd0;
      sh        <= 22'd0;
      skip      <= 1'b0;
      cap0      <= '0;
      cap1      <= '0;
      cap2      <= '0;
      temp0     <= 12'h000;
      temp1     <= 12'h000;
      temp2     <= 12'h000;
      ovf_tmp   <= 3'b000;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            cap0     <= bin0;
            cap1     <= bin1;
            cap2     <= bin2;
            ch       <= 2'd0;
            ovf_tmp  <= 3'b000;
            in_ready <= 1'b0;
            state    <= LOAD;
          end else begin
            in_ready <= 1'b1;
          end
        end
        LOAD: begin
          cnt   <= 4'd0;
          state <= SHIFT;
          if (sel > 10'd999) begin
            ovf_tmp[ch] <= 1'b1;
`ifdef OVF_BLANK_EN
            sh   <= {12'hFFF, 10'd0};
            skip <= 1'b1;
`else
            sh   <= {12'h000, 10'd999};
            skip <= 1'b0;
`endif
          end else begin
            sh   <= {12'h000, sel};
            skip <= 1'b0;
          end
        end
        SHIFT: begin
          if (!skip) begin
            sh <= {adj[10:0], sh[9:0], 1'b0};
          end else begin
            sh <= sh;
          end
          cnt <= cnt + 4'd1;
          if (cnt == 4'd9) begin
            state <= STORE;
          end else begin
            state <= SHIFT;
          end
        end
        STORE: begin
          case (ch)
            2'd0:    temp0 <= sh[21:10];
            2'd1:    temp1 <= sh[21:10];
            default: temp2 <= sh[21:10];
          endcase
          if (ch == 2'd2) begin
            in_ready <= 1'b1;
            state    <= DONE;
          end else begin
            ch    <= ch + 2'd1;
            state <= LOAD;
          end
        end
        DONE: begin
          dec0      <= temp0;
          dec1      <= temp1;
          dec2      <= temp2;
          ovf       <= ovf_tmp;
          out_valid <= 1'b1;
          // A handshake in this cycle starts the next triple straight away
          if (in_valid) begin
            cap0     <= bin0;
            cap1     <= bin1;
            cap2     <= bin2;
            ch       <= 2'd0;
            ovf_tmp  <= 3'b000;
            in_ready <= 1'b0;
            state    <= LOAD;
          end else begin
            in_ready <= 1'b1;
            state    <= IDLE;
          end
        end
        default: begin
          in_ready <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: directed vectors plus a per-channel value sweep.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        RSTn;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  bin0, bin1, bin2;
  logic [11:0] dec0, dec1, dec2;
  logic [2:0]  ovf;
  logic        out_valid;

  bin2bcd_seq #(.BIN_W(10)) dut (
    .clk(clk), .RSTn(RSTn), .in_valid(in_valid), .in_ready(in_ready),
    .bin0(bin0), .bin1(bin1), .bin2(bin2),
    .dec0(dec0), .dec1(dec1), .dec2(dec2), .ovf(ovf), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef OVF_BLANK_EN
  localparam logic [11:0] SAT = 12'hFFF;
`else
  localparam logic [11:0] SAT = 12'h999;
`endif

  typedef struct {
    logic [11:0] d0, d1, d2;
    logic [2:0]  ov;
    int          at;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [11:0] ref_bcd(input int n);
    if (n > 999) return SAT;
    return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  task automatic monitor();
    exp_t e;
    logic prev = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (prev) check("out_valid_twice", 32'(1), 32'(0));
        if (q.size() == 0) begin
          check("unexpected_out_valid", 32'(1), 32'(0));
        end else begin
          e = q.pop_front();
          check("dec0", 32'(dec0), 32'(e.d0));
          check("dec1", 32'(dec1), 32'(e.d1));
          check("dec2", 32'(dec2), 32'(e.d2));
          check("ovf", 32'(ovf), 32'(e.ov));
          check("latency", 32'(cyc), 32'(e.at));
        end
      end
      prev = out_valid;
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Present a triple, hold until accepted, queue the expected result; returns accepting edge index
  task automatic send(input logic [9:0] a, b, c, input logic [11:0] e0, e1, e2,
                      input logic [2:0] eo, output int acc);
    exp_t e;
    int t = 0;
    @(negedge clk);
    in_valid = 1'b1; bin0 = a; bin1 = b; bin2 = c;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    acc = cyc + 1;
    if (!in_ready) begin
      check("accept_timeout", 32'(0), 32'(1));
      in_valid = 1'b0;
      return;
    end
    e.d0 = e0; e.d1 = e1; e.d2 = e2; e.ov = eo; e.at = acc + 37;
    q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0; bin0 = ~a; bin1 = ~b; bin2 = ~c;
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("drain", 32'(q.size()), 32'(0));
  endtask

  initial begin
    int acc, acc2, x, y;
    RSTn = 1'b1; in_valid = 1'b0; bin0 = 10'd0; bin1 = 10'd0; bin2 = 10'd0;
    fork
      monitor();
    join_none
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_dec0", 32'(dec0), 32'(0));
    check("rst_dec1", 32'(dec1), 32'(0));
    check("rst_dec2", 32'(dec2), 32'(0));
    check("rst_ovf", 32'(ovf), 32'(0));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(1));
    RSTn = 1'b0;

    send(10'd0, 10'd9, 10'd999, 12'h000, 12'h009, 12'h999, 3'b000, acc);
    drain();
    send(10'd1000, 10'd1023, 10'd512, SAT, SAT, 12'h512, 3'b011, acc);
    drain();
    send(10'd57, 10'd100, 10'd990, 12'h057, 12'h100, 12'h990, 3'b000, acc);
    drain();

    // Busy-time pulses must be ignored; then a back-to-back accept in the done cycle
    send(10'd321, 10'd654, 10'd1001, 12'h321, 12'h654, SAT, 3'b100, acc);
    wait_until(acc + 4);
    in_valid = 1'b1; bin0 = 10'd11; bin1 = 10'd22; bin2 = 10'd33;
    check("busy_ready5", 32'(in_ready), 32'(0));
    @(negedge clk);
    in_valid = 1'b0;
    wait_until(acc + 19);
    in_valid = 1'b1; bin0 = 10'd44; bin1 = 10'd55; bin2 = 10'd66;
    check("busy_ready20", 32'(in_ready), 32'(0));
    @(negedge clk);
    in_valid = 1'b0;
    wait_until(acc + 35);
    send(10'd808, 10'd1, 10'd10, 12'h808, 12'h001, 12'h010, 3'b000, acc2);
    check("b2b_accept_edge", 32'(acc2), 32'(acc + 37));
    drain();

    // Reset mid-conversion discards the triple
    send(10'd123, 10'd456, 10'd789, 12'h123, 12'h456, 12'h789, 3'b000, acc);
    q.delete(q.size() - 1);
    wait_until(acc + 19);
    RSTn = 1'b1;
    @(negedge clk);
    RSTn = 1'b0;
    check("mid_rst_dec0", 32'(dec0), 32'(0));
    check("mid_rst_dec1", 32'(dec1), 32'(0));
    check("mid_rst_dec2", 32'(dec2), 32'(0));
    check("mid_rst_ovf", 32'(ovf), 32'(0));
    check("mid_rst_in_ready", 32'(in_ready), 32'(1));
    check("mid_rst_out_valid", 32'(out_valid), 32'(0));
    repeat (60) @(negedge clk);

    for (int n = 0; n < 1024; n++) begin
      x = 1023 - n;
      y = (n * 37 + 5) % 1024;
      send(10'(n), 10'(x), 10'(y), ref_bcd(n), ref_bcd(x), ref_bcd(y),
           {y > 999, x > 999, n > 999}, acc);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
